// File: rtl/cla_nibble_seq_adder.sv
// Multi-cycle WIDTH-bit add/subtract built on one time-shared 4-bit CLA slice, LS nibble first.
// Optional CLA_SEQ_SAT_EN: saturate the result on signed overflow instead of wrapping.
`default_nettype none

module cla_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       p_o,
  output logic       g_o
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;

  assign w_p = a_i ^ b_i;
  assign w_g = a_i & b_i;

  assign w_c[0] = cin_i;
  assign w_c[1] = w_g[0] | (w_p[0] & cin_i);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin_i);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin_i);

  assign sum_o = w_p ^ w_c;
  assign p_o   = &w_p;
  assign g_o   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

module cla_nibble_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;
  logic              done_q, done_d;

  logic [31:0]       w_base;
  logic [3:0]        w_sum;
  logic              w_p;
  logic              w_g;
  logic              w_last;
  logic              w_ovf;
  logic [WIDTH-1:0]  w_final;

  assign w_base = 32'(idx_q) << 2;
  assign w_last = (idx_q == IW'(N - 1));

  cla_4bit u_slice (
    .a_i   (a_q[w_base +: 4]),
    .b_i   (b_q[w_base +: 4]),
    .cin_i (carry_q),
    .sum_o (w_sum),
    .p_o   (w_p),
    .g_o   (w_g)
  );

  // b_q already holds the possibly-inverted operand, so one rule covers add and sub.
  assign w_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (shadow_q[WIDTH-1] != a_q[WIDTH-1]);

`ifdef CLA_SEQ_SAT_EN
  assign w_final = !w_ovf        ? shadow_q :
                   a_q[WIDTH-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                   {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_final = shadow_q;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    shadow_d = shadow_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i ^ {WIDTH{sub_i}};
          carry_d = sub_i;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        shadow_d[w_base +: 4] = w_sum;
        carry_d = w_g | (w_p & carry_q);
        idx_d   = idx_q + 1'b1;
        if (w_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        result_d = w_final;
        cout_d   = carry_q;
        ovf_d    = w_ovf;
        zero_d   = (w_final == '0);
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = (state_q == S_RUN);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign cout_o   = cout_q;
  assign ovf_o    = ovf_q;
  assign zero_o   = zero_q;
endmodule

`default_nettype wire

// File: tb/tb_cla_nibble_seq_adder.sv
// Self-checking bench for cla_nibble_seq_adder: directed cases plus random ops vs. an arithmetic model.
`default_nettype none

module tb_cla_nibble_seq_adder;
  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] last_res;

  cla_nibble_seq_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .sub_i    (sub),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result),
    .cout_o   (cout),
    .ovf_o    (ovf),
    .zero_o   (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  task automatic ref_model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                           output logic [W-1:0] r, output logic c, output logic o,
                           output logic z);
    logic [W:0] full;
    int sa;
    int sb;
    int t;
    full = s ? ({1'b0, av} + {1'b0, ~bv} + {{W{1'b0}}, 1'b1})
             : ({1'b0, av} + {1'b0, bv});
    sa = int'($signed(av));
    sb = int'($signed(bv));
    t  = s ? (sa - sb) : (sa + sb);
    o  = (t > 32767) || (t < -32768);
    r  = full[W-1:0];
`ifdef CLA_SEQ_SAT_EN
    if (o) r = (t > 0) ? 16'h7FFF : 16'h8000;
`endif
    c  = full[W];
    z  = (r == '0);
  endtask

  // Issue one request; returns #1 after the accept edge with operands scrambled.
  task automatic fire(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    sub   = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    sub   = 1'($urandom);
  endtask

  // Follows an accepted op from 'elapsed' edges after accept through the done pulse.
  task automatic follow(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                        input int elapsed);
    logic [W-1:0] er;
    logic ec, eo, ez;
    ref_model(av, bv, s, er, ec, eo, ez);
    for (int c = elapsed; c <= N + 2; c++) begin
      check("busy", W'(busy), W'(c < N));
      check("done", W'(done), W'(c == N + 1));
      if (c <= N) begin
        check("result_hold", result, last_res);
      end
      if (c == N + 1) begin
        check("result", result, er);
        check("cout", W'(cout), W'(ec));
        check("ovf", W'(ovf), W'(eo));
        check("zero", W'(zero), W'(ez));
        last_res = er;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
    fire(av, bv, s);
    follow(av, bv, s, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic rs;
    rst_n    = 1'b0;
    start    = 1'b0;
    sub      = 1'b0;
    a        = '0;
    b        = '0;
    last_res = '0;
    #1;
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_result", result, '0);
    check("rst_flags", W'({cout, ovf, zero}), '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h1111, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1);
    run_op(16'h0007, 16'h0005, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b1);
    run_op(16'h8000, 16'h8000, 1'b0);
    run_op(16'h1234, 16'h1234, 1'b1);

    // Start asserted during RUN must be ignored.
    fire(16'h0001, 16'h0001, 1'b0);
    follow(16'h0001, 16'h0001, 1'b0, 0);
    fire(16'h0001, 16'h0001, 1'b0);
    check("busy_c0", W'(busy), W'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    start = 1'b1;
    a     = 16'hAAAA;
    b     = 16'h5555;
    sub   = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    follow(16'h0001, 16'h0001, 1'b0, 2);
    run_op(16'hAAAA, 16'h5555, 1'b0);

    // Asynchronous reset mid-run.
    fire(16'h1234, 16'h1111, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", W'(busy), '0);
    check("arst_done", W'(done), '0);
    check("arst_result", result, '0);
    check("arst_flags", W'({cout, ovf, zero}), '0);
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk);
      #1;
      check("arst_no_done", W'({busy, done}), '0);
    end
    run_op(16'h1234, 16'h1111, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/cla_nibble_seq_adder.md
Name: cla_nibble_seq_adder

Overview:
- Multi-cycle WIDTH-bit add/subtract unit built on a single cla_4bit slice.
- The slice is time-shared across WIDTH/4 nibbles, least-significant first.
- Ripple carry between nibbles is held in a register, computed from the slice's P/G outputs.
- Serves the ALU as a low-area adder for wide ops; handshake is start/busy/done.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4; N = WIDTH/4 nibble steps.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when busy=0
- sub  in  1  0 = A+B, 1 = A-B; sampled with start
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- busy  out  1  high while nibble steps are in progress
- done  out  1  single-cycle pulse when the result updates
- result  out  WIDTH  sum/difference; held until next completion
- cout  out  1  final carry out (for sub: 1 = no borrow)
- ovf  out  1  signed overflow
- zero  out  1  result == 0

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; nibble index and carry register cleared.
  - busy, done, result, cout, ovf, zero are all 0.
  - Reset mid-operation aborts the operation; no done pulse; the previous result is lost.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge -> latch a, b^{WIDTH{sub}}, sub; carry reg <= sub; index <= 0; go to RUN.
  - RUN: busy=1. Each cycle the cla_4bit slice gets nibble[index] of A, B' and Cin = carry reg.
    - Write Sum into result-shadow nibble[index].
    - carry reg <= G | (P & carry reg).
    - index++.
    - After nibble N-1, go to DONE.
  - DONE: one cycle. Copy shadow into result and set cout/ovf/zero. done=1, busy=0. Return to IDLE.
- Latency: start accepted at edge k; busy high for edges k+1..k+N; done high in the cycle after edge k+N+1. Minimum issue interval is N+2 cycles.
- start while busy, or in DONE: ignored, not queued. Operands must not be assumed stable after the accept edge.
- start high in IDLE on consecutive cycles: each accept starts a new operation.
- cout: carry out of nibble N-1.
- ovf: (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), using the latched, possibly inverted, B'.
- zero: computed from the final result.
- Outputs change only in the DONE cycle; result stays stable between completions.
- WIDTH=4 degenerates to one RUN cycle; same protocol.

Optional Feature:
- Macro: CLA_SEQ_SAT_EN.
- Defined: on signed overflow, result saturates to 0111..1 (A positive) or 1000..0 (A negative). ovf still reports 1; zero is computed on the saturated value; cout is unchanged.
- Undefined: result wraps modulo 2^WIDTH; no saturation logic is present.

Test Plan:
1. WIDTH=16, a=0x1234, b=0x1111, sub=0, start 1 cycle -> busy for 4 cycles, then done pulse; result=0x2345, cout=0, ovf=0, zero=0.
2. a=0xFFFF, b=0x0001, sub=0 -> result=0x0000, cout=1, zero=1, ovf=0. Carry must ripple through all 4 nibbles.
3. a=0x7FFF, b=0x0001, sub=0 -> result=0x8000, ovf=1, cout=0. With CLA_SEQ_SAT_EN: result=0x7FFF, ovf=1.
4. a=0x0005, b=0x0007, sub=1 -> result=0xFFFE, cout=0 (borrow), ovf=0. Then a=0x0007, b=0x0005, sub=1 -> 0x0002, cout=1.
5. Start op 0x0001+0x0001, assert start with a=0xAAAA two cycles later -> second start ignored; result=0x0002 with exactly one done pulse. Next start after done is accepted.
6. Start 0x1234+0x1111, pulse rst_n low mid-RUN -> all outputs 0 immediately, no done pulse. A new start after reset completes normally with 0x2345.
